// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out front end with a shift stage and an output holding stage.
// Words leave on a valid/ready port; a completed word can wait in the shift stage.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             sync,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [WIDTH-1:0] pout_n;
  logic             pout_valid_n;
  logic [CW-1:0]    bit_cnt_n;

  logic [WIDTH-1:0] base;
  logic [CW-1:0]    cbase;
  logic [WIDTH-1:0] shifted;
  logic             acc;
  logic             slot_free;

  assign sin_ready = (bit_cnt != FULL);
  assign acc       = sin_valid && sin_ready;
  assign slot_free = !pout_valid || pout_ready;

  always_comb begin
    shreg_n      = shreg;
    pout_n       = pout;
    pout_valid_n = pout_valid;
    bit_cnt_n    = bit_cnt;
    // sync restarts alignment from an empty shift stage
    base    = sync ? '0 : shreg;
    cbase   = sync ? '0 : bit_cnt;
    shifted = MSB_FIRST ? {base[WIDTH-2:0], sin}
                        : {sin, base[WIDTH-1:1]};

    if (pout_valid && pout_ready)
      pout_valid_n = 1'b0;

    if (bit_cnt == FULL) begin
      if (slot_free) begin
        pout_n       = shreg;
        pout_valid_n = 1'b1;
        bit_cnt_n    = '0;
      end
    end else begin
      if (sync) begin
        shreg_n   = '0;
        bit_cnt_n = '0;
      end
      if (acc) begin
        shreg_n = shifted;
        if (cbase == LAST) begin
          if (slot_free) begin
            pout_n       = shifted;
            pout_valid_n = 1'b1;
            bit_cnt_n    = '0;
          end else begin
            bit_cnt_n = FULL;
          end
        end else begin
          bit_cnt_n = cbase + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      pout       <= '0;
      pout_valid <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      shreg      <= shreg_n;
      pout       <= pout_n;
      pout_valid <= pout_valid_n;
      bit_cnt    <= bit_cnt_n;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first and LSB-first instances
// share one stimulus stream; expected values are hand-computed.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst, sin, sin_valid, sync, pout_ready;
  logic       rdy, pv, rdy_l, pv_l;
  logic [3:0] po, po_l;
  logic [2:0] cnt, cnt_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(rdy), .sync(sync), .pout(po), .pout_valid(pv),
    .pout_ready(pout_ready), .bit_cnt(cnt)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(rdy_l), .sync(sync), .pout(po_l), .pout_valid(pv_l),
    .pout_ready(pout_ready), .bit_cnt(cnt_l)
  );

  typedef struct {
    logic       r, s, v, y, pr;
    logic [3:0] ep, epl;
    logic       epv;
    logic [2:0] ec;
    logic       er;
  } vec_t;

  vec_t q[$];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, s, v, y, pr,
                     input logic [3:0] ep, epl, input logic epv,
                     input logic [2:0] ec, input logic er);
    vec_t t;
    t = '{r, s, v, y, pr, ep, epl, epv, ec, er};
    q.push_back(t);
  endtask

  task automatic drive(input logic r, s, v, y, pr);
    @(negedge clk);
    rst = r; sin = s; sin_valid = v; sync = y; pout_ready = pr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] bits;
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; pout_ready = 1'b0;

    //   r  s  v  y  pr  pout   pout_l  pv ec rdy
    add(1, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 1); // 0 reset
    add(0, 1, 1, 0, 1, 4'h0, 4'h0, 0, 1, 1); // 1011 continuous
    add(0, 0, 1, 0, 1, 4'h0, 4'h0, 0, 2, 1);
    add(0, 1, 1, 0, 1, 4'h0, 4'h0, 0, 3, 1);
    add(0, 1, 1, 0, 1, 4'hB, 4'hD, 1, 0, 1);
    add(0, 0, 0, 0, 1, 4'hB, 4'hD, 0, 0, 1); // 5 one-cycle pulse
    add(0, 1, 1, 0, 1, 4'hB, 4'hD, 0, 1, 1); // gapped 1011
    add(0, 0, 0, 0, 1, 4'hB, 4'hD, 0, 1, 1);
    add(0, 1, 0, 0, 1, 4'hB, 4'hD, 0, 1, 1);
    add(0, 0, 1, 0, 1, 4'hB, 4'hD, 0, 2, 1);
    add(0, 1, 0, 0, 1, 4'hB, 4'hD, 0, 2, 1); // 10
    add(0, 0, 0, 0, 1, 4'hB, 4'hD, 0, 2, 1);
    add(0, 1, 1, 0, 1, 4'hB, 4'hD, 0, 3, 1);
    add(0, 0, 0, 0, 1, 4'hB, 4'hD, 0, 3, 1);
    add(0, 0, 0, 0, 1, 4'hB, 4'hD, 0, 3, 1);
    add(0, 1, 1, 0, 1, 4'hB, 4'hD, 1, 0, 1); // 15
    add(0, 0, 0, 0, 1, 4'hB, 4'hD, 0, 0, 1);
    add(0, 1, 1, 0, 1, 4'hB, 4'hD, 0, 1, 1); // 1,1 then sync
    add(0, 1, 1, 0, 1, 4'hB, 4'hD, 0, 2, 1);
    add(0, 0, 1, 1, 1, 4'hB, 4'hD, 0, 1, 1);
    add(0, 1, 1, 0, 1, 4'hB, 4'hD, 0, 2, 1); // 20
    add(0, 0, 1, 0, 1, 4'hB, 4'hD, 0, 3, 1);
    add(0, 1, 1, 0, 1, 4'h5, 4'hA, 1, 0, 1);
    add(0, 0, 0, 0, 1, 4'h5, 4'hA, 0, 0, 1);
    add(0, 1, 1, 0, 0, 4'h5, 4'hA, 0, 1, 1); // backpressure
    add(0, 0, 1, 0, 0, 4'h5, 4'hA, 0, 2, 1); // 25
    add(0, 1, 1, 0, 0, 4'h5, 4'hA, 0, 3, 1);
    add(0, 1, 1, 0, 0, 4'hB, 4'hD, 1, 0, 1);
    add(0, 0, 1, 0, 0, 4'hB, 4'hD, 1, 1, 1);
    add(0, 1, 1, 0, 0, 4'hB, 4'hD, 1, 2, 1);
    add(0, 1, 1, 0, 0, 4'hB, 4'hD, 1, 3, 1); // 30
    add(0, 0, 1, 0, 0, 4'hB, 4'hD, 1, 4, 0);
    add(0, 1, 1, 0, 0, 4'hB, 4'hD, 1, 4, 0);
    add(0, 1, 1, 0, 1, 4'h6, 4'h6, 1, 0, 1);
    add(0, 1, 1, 0, 0, 4'h6, 4'h6, 1, 1, 1);
    add(0, 0, 1, 0, 0, 4'h6, 4'h6, 1, 2, 1); // 35
    add(1, 1, 1, 0, 1, 4'h0, 4'h0, 0, 0, 1); // reset mid-word
    add(0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 1);

    foreach (q[i]) begin
      drive(q[i].r, q[i].s, q[i].v, q[i].y, q[i].pr);
      chk("pout",       i, 32'(po),    32'(q[i].ep));
      chk("pout_valid", i, 32'(pv),    32'(q[i].epv));
      chk("bit_cnt",    i, 32'(cnt),   32'(q[i].ec));
      chk("sin_ready",  i, 32'(rdy),   32'(q[i].er));
      chk("pout_lsb",   i, 32'(po_l),  32'(q[i].epl));
      chk("pv_lsb",     i, 32'(pv_l),  32'(q[i].epv));
      chk("cnt_lsb",    i, 32'(cnt_l), 32'(q[i].ec));
      chk("rdy_lsb",    i, 32'(rdy_l), 32'(q[i].er));
    end

    // continuous two-word stream, no bubbles
    bits = 8'b0110_1001;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, bits[7-k], 1'b1, 1'b0, 1'b1);
      chk("tp_cnt", 100 + k, 32'(cnt), 32'((k + 1) % 4));
      chk("tp_pv",  100 + k, 32'(pv),  32'(((k + 1) % 4) == 0));
      if (k == 3) chk("tp_word0", 100 + k, 32'(po), 32'h6);
      if (k == 7) chk("tp_word1", 100 + k, 32'(po), 32'h9);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("tp_drain", 108, 32'(pv), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
